// File: rtl/bp_fe_ltb_update_queue_pkg.sv
// Shared types for the LTB update queue: config selector, FSM states and the
// per-entry record macro (parameterised on address and count widths).
package bp_fe_ltb_update_queue_pkg;

    typedef enum logic {e_bp_default_cfg = 1'b0} bp_params_e;

    typedef enum logic {e_reset = 1'b0, e_run = 1'b1} bp_fe_ltb_update_queue_state_e;

    function automatic int vaddr_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: vaddr_width_f = 39;
            default:          vaddr_width_f = 39;
        endcase
    endfunction

    function automatic int ltb_cnt_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: ltb_cnt_width_f = 8;
            default:          ltb_cnt_width_f = 8;
        endcase
    endfunction

endpackage

`ifndef BP_FE_LTB_UPDATE_ENTRY_S_DECLARED
`define BP_FE_LTB_UPDATE_ENTRY_S_DECLARED
`define DECLARE_BP_FE_LTB_UPDATE_ENTRY_S(vaddr_width_mp, cnt_width_mp) \
    typedef struct packed {                         \
        logic [vaddr_width_mp-1:0] pc;              \
        logic                      pred_v;          \
        logic                      pred_taken;      \
        logic                      conf;            \
        logic [cnt_width_mp-1:0]   non_spec_cnt;    \
        logic [cnt_width_mp-1:0]   trip_cnt;        \
        logic                      taken;           \
        logic                      mispredict;      \
    } bp_fe_ltb_update_entry_s
`endif

// File: rtl/bp_fe_ltb_update_queue_mem.sv
// 1-write / 1-async-read entry store for the LTB update queue.
module bp_fe_ltb_update_queue_mem #(
    parameter  int width_p   = 1,
    parameter  int els_p     = 2,
    localparam int addr_w_lp = $clog2(els_p)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w_v,
    input  logic [addr_w_lp-1:0] w_addr,
    input  logic [width_p-1:0]   w_data,
    input  logic [addr_w_lp-1:0] r_addr,
    output logic [width_p-1:0]   r_data
);

    logic [els_p-1:0][width_p-1:0] mem_r;

    // Cleared on reset so the update fields read back as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= '0;
        end else if (w_v) begin
            mem_r[w_addr] <= w_data;
        end
    end

    assign r_data = mem_r[r_addr];

endmodule

// File: rtl/bp_fe_ltb_update_queue.sv
// In-order queue of LTB lookups captured at fetch, completed at resolve and sent to
// the LTB write port. Optional macro BP_FE_LTB_UPDATE_FILTER_EN drops miss/not-taken updates.
module bp_fe_ltb_update_queue
    import bp_fe_ltb_update_queue_pkg::*;
#(
    parameter  bp_params_e bp_params_p     = e_bp_default_cfg,
    parameter  int         depth_p         = 8,
    localparam int         vaddr_width_p   = vaddr_width_f(bp_params_p),
    localparam int         ltb_cnt_width_p = ltb_cnt_width_f(bp_params_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       alloc_v_i,
    output logic                       alloc_ready_o,
    input  logic [vaddr_width_p-1:0]   alloc_pc_i,
    input  logic                       alloc_pred_v_i,
    input  logic                       alloc_pred_taken_i,
    input  logic                       alloc_conf_i,
    input  logic [ltb_cnt_width_p-1:0] alloc_non_spec_cnt_i,
    input  logic [ltb_cnt_width_p-1:0] alloc_trip_cnt_i,
    input  logic                       res_v_i,
    input  logic                       res_taken_i,
    input  logic                       flush_i,
    output logic                       w_v_o,
    output logic                       br_mispredict_o,
    output logic                       br_taken_o,
    output logic                       br_conf_o,
    output logic [vaddr_width_p-1:0]   br_src_addr_o,
    output logic [ltb_cnt_width_p-1:0] br_non_spec_cnt_o,
    output logic [ltb_cnt_width_p-1:0] br_trip_cnt_o,
    input  logic                       w_yumi_i,
    output logic                       empty_o,
    output logic                       err_o
);

    localparam int idx_w_lp = $clog2(depth_p);
    localparam int ptr_w_lp = idx_w_lp + 1;
    localparam logic [ptr_w_lp-1:0] full_diff_lp = ptr_w_lp'(1) << idx_w_lp;

    `DECLARE_BP_FE_LTB_UPDATE_ENTRY_S(vaddr_width_p, ltb_cnt_width_p);

    bp_fe_ltb_update_queue_state_e state_r, state_n;

    logic [ptr_w_lp-1:0] head_r, res_r, tail_r;
    logic [ptr_w_lp-1:0] head_n, res_n, tail_n;
    logic [idx_w_lp-1:0] head_idx, res_idx, tail_idx;
    logic                err_r;
    logic [depth_p-1:0]  pred_taken_r, taken_r, mispredict_r;

    logic full, pending, skip, retire, alloc_fire, res_fire;
    bp_fe_ltb_update_entry_s wr_entry, head_entry;

    assign head_idx = head_r[idx_w_lp-1:0];
    assign res_idx  = res_r[idx_w_lp-1:0];
    assign tail_idx = tail_r[idx_w_lp-1:0];

    assign full    = (tail_r ^ head_r) == full_diff_lp;
    assign pending = head_r != res_r;

    always_comb begin
        state_n       = state_r;
        alloc_ready_o = 1'b0;
        case (state_r)
            e_reset: state_n = e_run;
            e_run:   alloc_ready_o = ~full & ~flush_i;
            default: state_n = e_reset;
        endcase
    end

    assign alloc_fire = alloc_v_i & alloc_ready_o;
    assign res_fire   = res_v_i & (res_r != tail_r);

`ifdef BP_FE_LTB_UPDATE_FILTER_EN
    // A miss that resolves not-taken teaches the LTB nothing; retire it locally.
    assign skip = pending & ~head_entry.pred_v & ~taken_r[head_idx];
`else
    assign skip = 1'b0;
`endif

    assign w_v_o  = pending & ~skip;
    assign retire = skip | (w_v_o & w_yumi_i);

    assign head_n = head_r + ptr_w_lp'(retire);
    assign res_n  = res_r + ptr_w_lp'(res_fire);
    // Flush trims back to the resolve point after this cycle's resolve.
    assign tail_n = flush_i ? res_n : tail_r + ptr_w_lp'(alloc_fire);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= e_reset;
            head_r  <= '0;
            res_r   <= '0;
            tail_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            head_r  <= head_n;
            res_r   <= res_n;
            tail_r  <= tail_n;
            err_r   <= err_r | (res_v_i & ~res_fire);
        end
    end

    always_comb begin
        wr_entry        = '0;
        wr_entry.pc     = alloc_pc_i;
        wr_entry.pred_v = alloc_pred_v_i;
        if (alloc_pred_v_i) begin
            wr_entry.pred_taken   = alloc_pred_taken_i;
            wr_entry.conf         = alloc_conf_i;
            wr_entry.non_spec_cnt = alloc_non_spec_cnt_i;
            wr_entry.trip_cnt     = alloc_trip_cnt_i;
        end
    end

    // Resolve fields live in flops so the entry store keeps a single write port.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pred_taken_r <= '0;
            taken_r      <= '0;
            mispredict_r <= '0;
        end else begin
            if (alloc_fire) begin
                pred_taken_r[tail_idx] <= alloc_pred_v_i & alloc_pred_taken_i;
            end
            if (res_fire) begin
                taken_r[res_idx]      <= res_taken_i;
                mispredict_r[res_idx] <= res_taken_i ^ pred_taken_r[res_idx];
            end
        end
    end

    bp_fe_ltb_update_queue_mem #(
        .width_p($bits(bp_fe_ltb_update_entry_s)),
        .els_p  (depth_p)
    ) entry_mem (
        .clk   (clk_i),
        .rst_n (reset_i),
        .w_v   (alloc_fire),
        .w_addr(tail_idx),
        .w_data(wr_entry),
        .r_addr(head_idx),
        .r_data(head_entry)
    );

    logic unused_fields;
    assign unused_fields = ^{head_entry.pred_v, head_entry.pred_taken,
                             head_entry.taken, head_entry.mispredict};

    assign br_src_addr_o     = head_entry.pc;
    assign br_conf_o         = head_entry.conf;
    assign br_non_spec_cnt_o = head_entry.non_spec_cnt;
    assign br_trip_cnt_o     = head_entry.trip_cnt;
    assign br_taken_o        = taken_r[head_idx];
    assign br_mispredict_o   = mispredict_r[head_idx];
    assign empty_o           = head_r == tail_r;
    assign err_o             = err_r;

endmodule
